bitmatrix_io: RTL and testbench
===============================

Name: bitmatrix_io

Overview:
- Parametrised DIM x DIM single-bit occupancy matrix with a serial coordinate-entry phase and a query phase.
- A fixed number of coordinates is loaded, each setting one cell. The block then answers cell, row-any and column-any queries, and can clear itself for a new load.
- Sits between the switch/button input layer and the LED output stage; all outputs are registered.

Parameters:
- DIM, 4, matrix dimension; power of two, 2..16.
- CW, $clog2(DIM), coordinate width; derived, not overridden.
- LOAD_CNT, 6, number of enter strobes in the load phase; 1..DIM*DIM.
- KW, $clog2(LOAD_CNT+1), load-counter width; derived.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enter  in  1  single-cycle strobe, already synchronised; qualifies x, y, op.
- x  in  CW  column coordinate.
- y  in  CW  row coordinate.
- op  in  2  query opcode; sampled only in QUERY.
- z  out  1  registered query result.
- z_valid  out  1  one-cycle pulse, aligned with each z update.
- state  out  2  IDLE=00, LOAD=01, QUERY=10; 11 unused.
- load_count  out  KW  number of strobes accepted in the current load.

Behaviour:
- Reset (asynchronous): state=IDLE, M all 0, load_count=0, z=0, z_valid=0. Reset mid-load or mid-query discards everything.
- Cell addressing: cell index = y*DIM + x; M is DIM*DIM bits.
- IDLE, enter: M[y][x]<=1 and load_count<=1.
  - Next state is QUERY if LOAD_CNT==1, otherwise LOAD.
- LOAD, enter: M[y][x]<=1 and load_count<=load_count+1.
  - The strobe that brings load_count to LOAD_CNT moves the block to QUERY on the same edge.
  - Duplicate coordinates still count; the cell simply stays 1.
- Strobe acceptance: one strobe per cycle. enter held high for k cycles = k strobes. enter low = hold everything.
- QUERY, enter: decode op.
  - op 00 (cell): z<=M[y][x].
  - op 01 (row-any): z<=OR of M[y][0..DIM-1]; x ignored.
  - op 10 (col-any): z<=OR of M[0..DIM-1][x]; y ignored.
  - op 11 (clear): M<=0, load_count<=0, state<=IDLE, z<=0.
  - z_valid<=1 for every QUERY-state enter, including clear.
- Result timing: z and z_valid change on the edge that samples enter, so they are visible in the cycle after the strobe. z holds between queries. z_valid is 0 in any cycle without a QUERY strobe.
- Outside QUERY: op is ignored, z holds, z_valid=0.
- load_count saturates at LOAD_CNT while in QUERY.
- No writes occur in QUERY except clear.
- Illegal state 11: recover to IDLE on the next edge with M cleared.
- No combinational path from any input to any output.

Test Plan:
- Reset, then enter (x,y) = (1,0),(3,0),(0,1),(2,2),(3,3),(1,3) with DIM=4, LOAD_CNT=6 -> state goes 00, 01 x5, then 10 after the 6th strobe; load_count = 1..6; z=0 and z_valid=0 throughout.
- Cell queries (op 00) after the load above:
  - (x=2,y=2) -> z=1, z_valid pulses 1 cycle.
  - (x=2,y=1) -> z=0.
  - (x=0,y=0) -> z=0.
- Aggregate queries after the same load:
  - op 01, y=1 -> z=1.
  - op 01, y=2 -> z=1.
  - op 10, x=2 -> z=1.
  - op 10, x=0 -> z=1.
  - Load with (1,0),(3,0),(0,1),(1,1),(3,3),(1,3), then op 01, y=2 -> z=0, and op 10, x=2 -> z=0.
- Duplicates and held enter:
  - Six strobes all at (0,0) -> QUERY reached, only M[0][0]=1; op 01, y=0 -> 1; op 01, y=1 -> 0.
  - enter held 3 cycles -> load_count advances by 3.
- Clear and reload: op 11 in QUERY -> state=00, load_count=0, z=0, z_valid pulse; a fresh load of (2,1)x6 then gives (x=1,y=2) -> z=0 (old data gone) and (x=2,y=1) -> z=1.
- Reset mid-operation and parameters:
  - rst asserted after 3 load strobes -> immediate state=00, load_count=0, M=0.
  - DIM=8, LOAD_CNT=1: one strobe at (7,7) -> QUERY; op 00 at (7,7) -> z=1; op 10, x=6 -> z=0.

Source files
------------

// File: rtl/bitmatrix_io.sv
// DIM x DIM occupancy matrix: a serial load of LOAD_CNT coordinates, then cell/row/column queries.
// Every output is registered, so no input reaches an output through a combinational path.
//
// state | meaning
// IDLE  | empty matrix, waiting for the first coordinate
// LOAD  | accepting coordinates until LOAD_CNT strobes have been taken
// QUERY | answering queries; op 11 clears the matrix and returns to IDLE
module bitmatrix_io #(
    parameter int DIM        = 4,
    parameter int LOAD_CNT   = 6,
    localparam int CW        = $clog2(DIM),
    localparam int KW        = $clog2(LOAD_CNT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enter,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [1:0]    op,
    output logic          z,
    output logic          z_valid,
    output logic [1:0]    state,
    output logic [KW-1:0] load_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        QUERY = 2'b10
    } state_t;

    localparam logic [KW-1:0] LAST_BEFORE_FULL = KW'(LOAD_CNT - 1);

    state_t                 state_q;
    logic [DIM*DIM-1:0]     m;
    logic [DIM-1:0]         row_any;
    logic [DIM-1:0]         col_any;
    logic [2*CW-1:0]        cell_idx;

    // DIM is a power of two, so y*DIM + x is simply the concatenation {y, x}.
    assign cell_idx = {y, x};
    assign state    = state_q;

    always_comb begin
        row_any = '0;
        col_any = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                row_any[r] = row_any[r] | m[r*DIM + c];
                col_any[c] = col_any[c] | m[r*DIM + c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            m          <= '0;
            load_count <= '0;
            z          <= 1'b0;
            z_valid    <= 1'b0;
        end else begin
            z_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enter) begin
                        m[cell_idx] <= 1'b1;
                        load_count  <= KW'(1);
                        state_q     <= (LOAD_CNT == 1) ? QUERY : LOAD;
                    end
                end
                LOAD: begin
                    if (enter) begin
                        m[cell_idx] <= 1'b1;
                        load_count  <= load_count + 1'b1;
                        if (load_count == LAST_BEFORE_FULL) begin
                            state_q <= QUERY;
                        end
                    end
                end
                QUERY: begin
                    if (enter) begin
                        z_valid <= 1'b1;
                        case (op)
                            2'b00: z <= m[cell_idx];
                            2'b01: z <= row_any[y];
                            2'b10: z <= col_any[x];
                            default: begin
                                z          <= 1'b0;
                                m          <= '0;
                                load_count <= '0;
                                state_q    <= IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    // Unreachable encoding 11: recover cleanly with an empty matrix.
                    state_q    <= IDLE;
                    m          <= '0;
                    load_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitmatrix_io.sv
// Scoreboard bench for bitmatrix_io: a 4x4/6-load instance and an 8x8/1-load instance.
// Stimulus pushes expected z values; monitors pop and compare on every z_valid pulse.
module tb_bitmatrix_io;

    logic       clk;
    logic       rst;

    logic       enter4, enter8;
    logic [1:0] x4, y4, op4, op8;
    logic [2:0] x8, y8;
    logic       z4, z8, zv4, zv8;
    logic [1:0] st4, st8;
    logic [2:0] lc4;
    logic [0:0] lc8;

    int checks = 0;
    int errors = 0;

    logic q4[$];
    logic q8[$];

    bitmatrix_io #(.DIM(4), .LOAD_CNT(6)) u_dut4 (
        .clk(clk), .rst(rst), .enter(enter4), .x(x4), .y(y4), .op(op4),
        .z(z4), .z_valid(zv4), .state(st4), .load_count(lc4)
    );

    bitmatrix_io #(.DIM(8), .LOAD_CNT(1)) u_dut8 (
        .clk(clk), .rst(rst), .enter(enter8), .x(x8), .y(y8), .op(op8),
        .z(z8), .z_valid(zv8), .state(st8), .load_count(lc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic e;
        if (!rst && zv4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL z4_unexpected actual z=%0b required no pulse", z4);
            end else begin
                e = q4.pop_front();
                if (z4 !== e) begin
                    errors++;
                    $display("FAIL z4 actual=%0b required=%0b", z4, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic e;
        if (!rst && zv8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL z8_unexpected actual z=%0b required no pulse", z8);
            end else begin
                e = q8.pop_front();
                if (z8 !== e) begin
                    errors++;
                    $display("FAIL z8 actual=%0b required=%0b", z8, e);
                end
            end
        end
    end

    // One-cycle strobe on the 4x4 instance; returns just after the sampling edge.
    task automatic s4(input int xx, input int yy, input logic [1:0] o);
        @(posedge clk); #1;
        x4 = 2'(xx); y4 = 2'(yy); op4 = o; enter4 = 1'b1;
        @(posedge clk); #1;
        enter4 = 1'b0;
    endtask

    task automatic q4_push(input int xx, input int yy, input logic [1:0] o, input logic exp);
        q4.push_back(exp);
        s4(xx, yy, o);
    endtask

    task automatic load_same(input int xx, input int yy);
        for (int i = 0; i < 6; i++) s4(xx, yy, 2'b00);
        chk("same_load_state", st4, 2);
    endtask

    task automatic clear4;
        q4_push(0, 0, 2'b11, 1'b0);
        chk("clear_state", st4, 0);
        chk("clear_load_count", lc4, 0);
    endtask

    int ax[6] = '{1, 3, 0, 2, 3, 1};
    int ay[6] = '{0, 0, 1, 2, 3, 3};
    int bx[6] = '{1, 3, 0, 1, 3, 1};
    int by[6] = '{0, 0, 1, 1, 3, 3};

    initial begin
        rst = 1'b1;
        enter4 = 1'b0; enter8 = 1'b0;
        x4 = '0; y4 = '0; op4 = '0;
        x8 = '0; y8 = '0; op8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", st4, 0);
        chk("reset_load_count", lc4, 0);
        chk("reset_z", z4, 0);
        chk("reset_z_valid", zv4, 0);
        rst = 1'b0;

        // Load A: op bits deliberately nonzero to show op is ignored outside QUERY.
        for (int i = 0; i < 6; i++) begin
            s4(ax[i], ay[i], 2'b11);
            chk("loadA_state", st4, (i == 5) ? 2 : 1);
            chk("loadA_load_count", lc4, i + 1);
            chk("loadA_z", z4, 0);
            chk("loadA_z_valid", zv4, 0);
        end

        q4_push(2, 2, 2'b00, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("z_hold", z4, 1);
        chk("z_valid_one_cycle", zv4, 0);
        q4_push(2, 1, 2'b00, 1'b0);
        q4_push(0, 0, 2'b00, 1'b0);
        q4_push(3, 1, 2'b01, 1'b1);
        q4_push(0, 2, 2'b01, 1'b1);
        q4_push(2, 3, 2'b10, 1'b1);
        q4_push(0, 0, 2'b10, 1'b1);
        chk("query_load_count_sat", lc4, 6);
        chk("query_state", st4, 2);
        clear4();

        for (int i = 0; i < 6; i++) s4(bx[i], by[i], 2'b00);
        chk("loadB_state", st4, 2);
        q4_push(0, 2, 2'b01, 1'b0);
        q4_push(2, 0, 2'b10, 1'b0);
        clear4();

        load_same(0, 0);
        q4_push(3, 0, 2'b01, 1'b1);
        q4_push(0, 1, 2'b01, 1'b0);
        clear4();

        load_same(2, 1);
        q4_push(0, 0, 2'b00, 1'b0);
        q4_push(1, 2, 2'b00, 1'b0);
        q4_push(2, 1, 2'b00, 1'b1);
        clear4();

        // Held enter: three consecutive strobes.
        @(posedge clk); #1;
        x4 = 2'd1; y4 = 2'd1; op4 = 2'b00; enter4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        enter4 = 1'b0;
        chk("held_load_count", lc4, 3);
        chk("held_state", st4, 1);

        #2 rst = 1'b1;
        #1;
        chk("midrst_state", st4, 0);
        chk("midrst_load_count", lc4, 0);
        #1 rst = 1'b0;
        load_same(3, 3);
        q4_push(1, 1, 2'b00, 1'b0);
        q4_push(3, 3, 2'b00, 1'b1);

        // 8x8, single-coordinate load.
        @(posedge clk); #1;
        x8 = 3'd7; y8 = 3'd7; op8 = 2'b00; enter8 = 1'b1;
        @(posedge clk); #1;
        enter8 = 1'b0;
        chk("d8_state", st8, 2);
        chk("d8_load_count", lc8, 1);
        chk("d8_z_valid_load", zv8, 0);
        q8.push_back(1'b1);
        @(posedge clk); #1;
        x8 = 3'd7; y8 = 3'd7; op8 = 2'b00; enter8 = 1'b1;
        @(posedge clk); #1;
        enter8 = 1'b0;
        q8.push_back(1'b0);
        @(posedge clk); #1;
        x8 = 3'd6; y8 = 3'd7; op8 = 2'b10; enter8 = 1'b1;
        @(posedge clk); #1;
        enter8 = 1'b0;

        repeat (4) @(posedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
